// File: rtl/fsm_pkg.sv
// Shared encodings for the symbol arbiter and the 6-state one-hot FSM it feeds.
package fsm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    G0   = 3'b010,
    G1   = 3'b100
  } arb_state_e;

  typedef enum logic [5:0] {
    S0 = 6'b000001,
    S1 = 6'b000010,
    S2 = 6'b000100,
    S3 = 6'b001000,
    S4 = 6'b010000,
    S5 = 6'b100000
  } fsm_state_e;

endpackage

// File: rtl/fsm.sv
// Shared 6-state one-hot FSM: ab=11 advances one state, ab=10 jumps two from an
// even state, ab=01 returns to S0, ab=00 holds. out is high in odd states.
module fsm
  import fsm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic out
);

  fsm_state_e state_q, state_d;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case ({a, b})
      2'b11: state_d = fsm_state_e'({state_q[4:0], state_q[5]});
      2'b10: begin
        if (state_q[0] | state_q[2] | state_q[4]) begin
          state_d = fsm_state_e'({state_q[3:0], state_q[5:4]});
        end
      end
      2'b01:   state_d = S0;
      default: state_d = state_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign out = state_q[1] | state_q[3] | state_q[5];

endmodule

// File: rtl/fsm_sym_arbiter.sv
// Two-requester burst arbiter that feeds one symbol per cycle into a shared FSM
// and routes the FSM's response back to the requester whose symbol it consumed.
module fsm_sym_arbiter
  import fsm_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter logic        IDLE_A    = 1'b0,
  parameter logic        IDLE_B    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic a0,
  input  logic b0,
  input  logic a1,
  input  logic b1,
  input  logic lock0,
  input  logic lock1,
  input  logic fsm_out,
  output logic fsm_a,
  output logic fsm_b,
  output logic gnt0,
  output logic gnt1,
  output logic rsp_valid0,
  output logic rsp_valid1,
  output logic rsp_out
);

  localparam logic [2:0] MaxCnt = 3'(MAX_BURST);

  arb_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_served_q, last_served_d;
  logic       rsp_valid0_q, rsp_valid1_q;
  logic       burst_done;

  assign gnt0 = (state_q == G0) & req0;
  assign gnt1 = (state_q == G1) & req1;

  assign fsm_a = gnt0 ? a0 : (gnt1 ? a1 : IDLE_A);
  assign fsm_b = gnt0 ? b0 : (gnt1 ? b1 : IDLE_B);

  // True when the grant in this cycle brings the burst count up to MAX_BURST.
  assign burst_done = (cnt_q >= MaxCnt - 3'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = last_served_q ? G0 : G1;
        else if (req0)    state_d = G0;
        else if (req1)    state_d = G1;
      end
      G0: begin
        if (!req0)                            state_d = req1 ? G1 : IDLE;
        else if (burst_done && !lock0 && req1) state_d = G1;
      end
      G1: begin
        if (!req1)                            state_d = req0 ? G0 : IDLE;
        else if (burst_done && !lock1 && req0) state_d = G0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    last_served_d = last_served_q;
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_q == G0)      last_served_d = 1'b0;
      else if (state_q == G1) last_served_d = 1'b1;
    end else if ((gnt0 || gnt1) && (cnt_q < MaxCnt)) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_served_q <= 1'b1;
      rsp_valid0_q  <= 1'b0;
      rsp_valid1_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_served_q <= last_served_d;
      rsp_valid0_q  <= gnt0;
      rsp_valid1_q  <= gnt1;
    end
  end

  assign rsp_valid0 = rsp_valid0_q;
  assign rsp_valid1 = rsp_valid1_q;
  assign rsp_out    = fsm_out & (rsp_valid0_q | rsp_valid1_q);

endmodule

// File: tb/tb_fsm_sym_arbiter.sv
// Directed and randomised bench for fsm_sym_arbiter driving the shared fsm.
module tb_fsm_sym_arbiter;
  import fsm_pkg::*;

  localparam int   MB       = 4;
  localparam logic IDLE_A_P = 1'b0;
  localparam logic IDLE_B_P = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 0, req1 = 0, a0 = 0, b0 = 0, a1 = 0, b1 = 0, lock0 = 0, lock1 = 0;
  logic fsm_out, fsm_a, fsm_b, gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm_sym_arbiter #(.MAX_BURST(MB), .IDLE_A(IDLE_A_P), .IDLE_B(IDLE_B_P)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .a0(a0), .b0(b0),
    .a1(a1), .b1(b1), .lock0(lock0), .lock1(lock1), .fsm_out(fsm_out),
    .fsm_a(fsm_a), .fsm_b(fsm_b), .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1), .rsp_out(rsp_out)
  );

  fsm u_fsm (.clk(clk), .reset(reset), .a(fsm_a), .b(fsm_b), .out(fsm_out));

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {req0, req1, a0, b0, a1, b1, lock0, lock1} = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    a0 = 1'b1;
    b0 = 1'b1;
    do_reset();
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, fsm_a, fsm_b, rsp_valid0, rsp_valid1} !== {2'b00, IDLE_A_P, IDLE_B_P, 2'b00}) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b",
               {gnt0, gnt1, fsm_a, fsm_b, rsp_valid0, rsp_valid1}, {2'b00, IDLE_A_P, IDLE_B_P, 2'b00});
    end
    checks++;
    if (dut.state_q !== IDLE || dut.cnt_q !== 3'd0 || dut.last_served_q !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got state=%b cnt=%0d last=%b expected state=001 cnt=0 last=1",
               dut.state_q, dut.cnt_q, dut.last_served_q);
    end
    checks++;
    if (u_fsm.state_q !== S0) begin
      errors++;
      $display("FAIL reset_fsm: got %b expected %b", u_fsm.state_q, S0);
    end
    clear_inputs();
    next_cyc();
  endtask

  task automatic test_single();
    logic [2:0] stim [6];
    logic [4:0] expv [6];
    fsm_state_e expf [6];
    // stim = {req0,a0,b0}; expv = {gnt0,fsm_a,fsm_b,rsp_valid0,rsp_out}
    stim = '{3'b111, 3'b111, 3'b100, 3'b110, 3'b000, 3'b000};
    expv = '{5'b00000, 5'b11100, 5'b10011, 5'b11011, 5'b00011, 5'b00000};
    expf = '{S0, S0, S1, S1, S1, S1};
    clear_inputs();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      {req0, a0, b0} = stim[c];
      @(negedge clk);
      checks++;
      if ({gnt0, fsm_a, fsm_b, rsp_valid0, rsp_out} !== expv[c]) begin
        errors++;
        $display("FAIL single_outputs cycle %0d: got %b expected %b",
                 c + 1, {gnt0, fsm_a, fsm_b, rsp_valid0, rsp_out}, expv[c]);
      end
      checks++;
      if (u_fsm.state_q !== expf[c]) begin
        errors++;
        $display("FAIL single_fsm cycle %0d: got %b expected %b", c + 1, u_fsm.state_q, expf[c]);
      end
      next_cyc();
    end
    clear_inputs();
  endtask

  task automatic test_tie();
    logic [1:0] exp_g;
    clear_inputs();
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      exp_g = (c == 1) ? 2'b00 : (c <= 5) ? 2'b10 : (c <= 9) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== exp_g) begin
        errors++;
        $display("FAIL tie_grants cycle %0d: got %b expected %b", c, {gnt0, gnt1}, exp_g);
      end
      next_cyc();
    end
    clear_inputs();
  endtask

  task automatic test_lock();
    logic [1:0] exp_g;
    clear_inputs();
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      lock0 = (c < 12);
      exp_g = (c == 1) ? 2'b00 : (c <= 12) ? 2'b10 : 2'b01;
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== exp_g) begin
        errors++;
        $display("FAIL lock_grants cycle %0d: got %b expected %b", c, {gnt0, gnt1}, exp_g);
      end
      if (c == 11) begin
        checks++;
        if (dut.cnt_q !== 3'(MB)) begin
          errors++;
          $display("FAIL lock_cnt_saturate: got %0d expected %0d", dut.cnt_q, MB);
        end
      end
      next_cyc();
    end
    clear_inputs();
  endtask

  task automatic test_early_release();
    logic [1:0] exp_g;
    clear_inputs();
    do_reset();
    req1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      req0 = (c <= 3);
      exp_g = (c == 1 || c == 4) ? 2'b00 : (c <= 3) ? 2'b10 : 2'b01;
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== exp_g) begin
        errors++;
        $display("FAIL release_grants cycle %0d: got %b expected %b", c, {gnt0, gnt1}, exp_g);
      end
      if (c == 5) begin
        checks++;
        if (dut.cnt_q !== 3'd0 || dut.last_served_q !== 1'b0) begin
          errors++;
          $display("FAIL release_state: got cnt=%0d last=%b expected cnt=0 last=0",
                   dut.cnt_q, dut.last_served_q);
        end
      end
      next_cyc();
    end
    clear_inputs();
  endtask

  task automatic test_idle();
    clear_inputs();
    do_reset();
    {a0, b0, a1, b1} = 4'b1111;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, fsm_a, fsm_b, rsp_valid0, rsp_valid1} !== {2'b00, IDLE_A_P, IDLE_B_P, 2'b00}) begin
        errors++;
        $display("FAIL idle_outputs cycle %0d: got %b expected %b", c,
                 {gnt0, gnt1, fsm_a, fsm_b, rsp_valid0, rsp_valid1}, {2'b00, IDLE_A_P, IDLE_B_P, 2'b00});
      end
      next_cyc();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    clear_inputs();
    do_reset();
    req1 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== ((c == 1) ? 2'b00 : 2'b01)) begin
        errors++;
        $display("FAIL midrst_grants cycle %0d: got %b expected %b", c, {gnt0, gnt1},
                 (c == 1) ? 2'b00 : 2'b01);
      end
      if (c == 3) reset = 1'b1;
      next_cyc();
    end
    reset = 1'b0;
    req0  = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.state_q !== IDLE || {gnt0, gnt1, rsp_valid0, rsp_valid1} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_after: got state=%b g/rv=%b expected state=001 g/rv=0000",
               dut.state_q, {gnt0, gnt1, rsp_valid0, rsp_valid1});
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, rsp_valid0, rsp_valid1} !== 4'b1000) begin
      errors++;
      $display("FAIL midrst_tie: got %b expected 1000", {gnt0, gnt1, rsp_valid0, rsp_valid1});
    end
    next_cyc();
    clear_inputs();
  endtask

  task automatic test_random();
    int ms, mcnt, mlast, mfsm, nxt;
    logic mrv0, mrv1, g0, g1, fa, fb, ro, own_req, oth_req, own_lock;
    logic [6:0] exp_v, got_v;
    clear_inputs();
    do_reset();
    ms = 0; mcnt = 0; mlast = 1; mfsm = 0; mrv0 = 1'b0; mrv1 = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      req0  = ($urandom_range(3) != 0);
      req1  = ($urandom_range(3) != 0);
      lock0 = ($urandom_range(3) == 0);
      lock1 = ($urandom_range(3) == 0);
      a0 = ($urandom_range(1) == 1);
      b0 = ($urandom_range(1) == 1);
      a1 = ($urandom_range(1) == 1);
      b1 = ($urandom_range(1) == 1);
      @(negedge clk);
      g0 = (ms == 1) && req0;
      g1 = (ms == 2) && req1;
      fa = g0 ? a0 : (g1 ? a1 : IDLE_A_P);
      fb = g0 ? b0 : (g1 ? b1 : IDLE_B_P);
      ro = (mrv0 || mrv1) && (mfsm % 2 == 1);
      exp_v = {g0, g1, fa, fb, mrv0, mrv1, ro};
      got_v = {gnt0, gnt1, fsm_a, fsm_b, rsp_valid0, rsp_valid1, rsp_out};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL rand_outputs cycle %0d: got %b expected %b", c, got_v, exp_v);
      end
      checks++;
      if (!$onehot(dut.state_q) || (gnt0 && gnt1)) begin
        errors++;
        $display("FAIL rand_onehot cycle %0d: got state=%b grants=%b expected one-hot, exclusive",
                 c, dut.state_q, {gnt0, gnt1});
      end
      checks++;
      if (u_fsm.state_q !== 6'(1 << mfsm)) begin
        errors++;
        $display("FAIL rand_fsm cycle %0d: got %b expected %b", c, u_fsm.state_q, 6'(1 << mfsm));
      end
      @(posedge clk);
      nxt = ms;
      if (ms == 0) begin
        if (req0 && req1) nxt = (mlast == 1) ? 1 : 2;
        else if (req0)    nxt = 1;
        else if (req1)    nxt = 2;
      end else begin
        own_req  = (ms == 1) ? req0 : req1;
        oth_req  = (ms == 1) ? req1 : req0;
        own_lock = (ms == 1) ? lock0 : lock1;
        if (!own_req)                                 nxt = oth_req ? 3 - ms : 0;
        else if (mcnt + 1 >= MB && !own_lock && oth_req) nxt = 3 - ms;
      end
      if (nxt != ms) begin
        if (ms != 0) mlast = ms - 1;
        mcnt = 0;
      end else if (g0 || g1) begin
        mcnt = (mcnt + 1 > MB) ? MB : mcnt + 1;
      end
      ms   = nxt;
      mrv0 = g0;
      mrv1 = g1;
      if (fa && fb)       mfsm = (mfsm + 1) % 6;
      else if (fa && !fb) mfsm = (mfsm % 2 == 0) ? (mfsm + 2) % 6 : mfsm;
      else if (!fa && fb) mfsm = 0;
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_lock();
    test_early_release();
    test_idle();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_sym_arbiter.md
FSM_SYM_ARBITER -- requirements
Module: fsm_sym_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4: symbols one requester may consume per grant before yielding (range 1..7).
REQ-002 SHALL have parameters IDLE_A and IDLE_B, default 0 and 0: symbol driven to the FSM when no grant is active.
REQ-003 SHALL have ports, in order:
 clk  in  1  single clock; all state updates on posedge.
 reset  in  1  synchronous, active-high.
 req0 / req1  in  1  requester i presents a valid symbol.
 a0, b0 / a1, b1  in  1 each  requester i symbol bits.
 lock0 / lock1  in  1  requester i holds its grant past MAX_BURST.
 fsm_out  in  1  output of the shared 6-state one-hot FSM.
 fsm_a, fsm_b  out  1 each  symbol to the shared FSM a/b inputs.
 gnt0 / gnt1  out  1  requester i symbol consumed this cycle.
 rsp_valid0 / rsp_valid1  out  1  FSM response for requester i is valid.
 rsp_out  out  1  FSM response bit.

Function
REQ-004 SHALL implement a one-hot arbiter state machine with states IDLE=3'b001, G0=3'b010 and G1=3'b100.
REQ-005 SHALL assert gnt_i combinationally, as (state==Gi) & req_i, so that at most one grant is high per cycle.
REQ-006 SHALL drive fsm_a/fsm_b combinationally: {a_i,b_i} when gnt_i is high, else {IDLE_A,IDLE_B}.
REQ-007 SHALL, in IDLE, go to G0 if only req0 is high, G1 if only req1 is high, and to the requester not equal to last_served if both are high; otherwise it stays in IDLE. A grant therefore appears one cycle after req first rises.
REQ-008 SHALL keep a burst counter cnt (3 bits): it increments on each gnt_i, clears on every state change, and saturates at MAX_BURST.
REQ-009 SHALL, in Gi with req_i high, switch to G_other at the edge where cnt reaches MAX_BURST, provided lock_i is low and req_other is high; otherwise it stays in Gi.
REQ-010 SHALL, in Gi with req_i low, go to G_other if req_other is high, else IDLE. Release takes effect at the next edge.
REQ-011 SHALL update last_served to i on every exit from Gi.
REQ-012 SHALL not switch away from Gi while lock_i is high and req_i is high, regardless of cnt. cnt then stays saturated at MAX_BURST.
REQ-013 SHALL register rsp_valid_i <= gnt_i, giving 1-cycle response latency.
REQ-014 SHALL drive rsp_out = fsm_out while either rsp_valid is high, else 0.
REQ-015 SHALL, for a symbol consumed at cycle t, report the FSM state reached at edge t in cycle t+1.
REQ-016 SHALL treat req_i dropping in the same cycle as its final grant as a normal release; that final symbol is still consumed and responded to.
REQ-017 SHALL, when both requests rise in the same cycle from IDLE, grant per last_served. Two consecutive ties SHALL alternate.

Reset
REQ-018 SHALL, with reset high at a posedge, set state=IDLE, cnt=0, last_served=1 (so req0 wins the first tie), and rsp_valid0=rsp_valid1=0.
REQ-019 SHALL hold gnt0=gnt1=0 and fsm_a/fsm_b={IDLE_A,IDLE_B} during the cycle after reset is sampled.
REQ-020 SHALL drop any in-flight response on reset mid-burst: rsp_valid stays 0, with no stale response afterwards.

Structure
REQ-021 SHALL place the one-hot state encodings (IDLE/G0/G1) and the FSM one-hot encodings (S0=6'b000001 .. S5=6'b100000) in a shared package, fsm_pkg, used by RTL and bench.
REQ-022 SHALL be a single module with no sub-modules. The bench instantiates fsm alongside fsm_sym_arbiter, with fsm_a/fsm_b wired to FSM a/b, fsm_out to FSM out, and a common clk/reset.

Verification
REQ-023 Single requester: req0=1 with symbols (1,1),(0,0),(1,0) from FSM S0 -> gnt0 on cycles 2..4, FSM S0->S1->S1->S1, rsp_valid0 on cycles 3..5, rsp_out equal to FSM out each cycle.
REQ-024 Tie after reset: req0=req1=1 held -> G0 for 4 grants, then G1 for 4, then G0. Never both grants high.
REQ-025 Lock: req0, lock0 and req1 high for 10 cycles -> gnt0 on all 10, gnt1 never. Lock0 falls -> G1 on the next edge.
REQ-026 Early release: req0 drops after 2 grants with req1 high -> gnt1 is the next cycle, cnt=0, last_served=0.
REQ-027 Idle symbol: no requests for 5 cycles -> fsm_a/fsm_b=IDLE_A/IDLE_B, gnt=0, rsp_valid=0.
REQ-028 Reset mid-burst: reset during the 2nd grant of G1 -> next cycle state IDLE, rsp_valid1=0, and the next tie grants req0. Then 1000 cycles of random req/lock/a/b, with the bench checking one-hot state, mutual grant exclusion, and FSM state matching the reference model.
